// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the capture controller; the sample RAM and upload
// blocks reuse the default geometry and the state encoding from here.
package capture_ctrl_pkg;

  localparam int CAPTURE_ADDR_W    = 10;
  localparam int CAPTURE_PRE_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } cap_state_t;

  // True in the states that write the sample RAM.
  function automatic logic is_capturing(input cap_state_t s);
    return (s == ARM) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture controller: drives the circular sample RAM write
// port and hands the oldest-sample address to the upload stage.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int ADDR_W    = CAPTURE_ADDR_W,
  parameter int PRE_DEPTH = CAPTURE_PRE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_flag,
  input  logic              stop_flag,
  input  logic              sample_en,
  input  logic              trig_hit,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [ADDR_W-1:0] start_addr
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  PRE_TARGET  = CNT_W'(PRE_DEPTH);
  localparam logic [CNT_W-1:0]  POST_TARGET = CNT_W'(DEPTH - PRE_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PRE_OFFSET  = ADDR_W'(PRE_DEPTH);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d, pre_cnt_inc;
  logic [CNT_W-1:0]  post_cnt_q, post_cnt_d, post_cnt_inc;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              busy_q;
  logic              done_valid_q;
  logic [ADDR_W-1:0] start_addr_q;

  assign wr_en      = sample_en & is_capturing(state_q);
  assign wr_addr    = wr_addr_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign start_addr = start_addr_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    pre_cnt_inc  = pre_cnt_q + 1'b1;
    post_cnt_inc = post_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        // A simultaneous stop press cancels the start.
        if (start_flag && !stop_flag) begin
          pre_cnt_d = '0;
          state_d   = (PRE_DEPTH == 0) ? WAIT_TRIG : ARM;
        end
      end
      ARM: begin
        if (stop_flag) begin
          state_d = IDLE;
        end else if (sample_en) begin
          pre_cnt_d = pre_cnt_inc;
          if (pre_cnt_inc == PRE_TARGET) state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (stop_flag) begin
          state_d = IDLE;
        end else if (sample_en && trig_hit) begin
          trig_addr_d = wr_addr_q;
          post_cnt_d  = CNT_ONE;
          state_d     = (POST_TARGET == CNT_ONE) ? DONE : POST;
        end
      end
      POST: begin
        if (stop_flag) begin
          state_d = IDLE;
        end else if (sample_en) begin
          post_cnt_d = post_cnt_inc;
          if (post_cnt_inc == POST_TARGET) state_d = DONE;
        end
      end
      DONE: begin
        // done_valid is high throughout DONE, so ready alone completes the handshake.
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      start_addr_q <= '0;
    end else begin
      if (wr_en) wr_addr_q <= wr_addr_q + 1'b1;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      busy_q       <= is_capturing(state_d);
      done_valid_q <= (state_d == DONE);
      // Load once on entry so the result stays frozen while the upload stage stalls.
      if (state_d == DONE && state_q != DONE) start_addr_q <= trig_addr_d - PRE_OFFSET;
    end
  end

endmodule
